// File: rtl/bit_serial_mult_unit_if.sv
// Operand/product handshake bundle for bit_serial_mult_unit.
// ACCUMULATE_MODE_EN adds the in_clear operand-side signal.
interface bit_serial_mult_unit_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;
  logic           busy;
`ifdef ACCUMULATE_MODE_EN
  logic           in_clear;
`endif

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
`ifdef ACCUMULATE_MODE_EN
    output in_clear,
`endif
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
`ifdef ACCUMULATE_MODE_EN
    input  in_clear,
`endif
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/bit_serial_mult_unit.sv
// Handshaked serial-parallel multiplier: a held in parallel, b consumed LSB-first.
// Optional ACCUMULATE_MODE_EN turns the result register into a running accumulator.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one multiplier bit per clock, N clocks
// DONE  | product presented until out_ready
module bit_serial_mult_unit #(
  parameter  int N     = 8,
  localparam int CNT_W = $clog2(N)
) (
  input logic clk,
  input logic reset_n,
  bit_serial_mult_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           sgn_q;
  logic [N:0]     part_q;
  logic [N-1:0]   low_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*N-1:0] result_q;
`ifdef ACCUMULATE_MODE_EN
  logic           clr_q;
`endif

  logic           accept;
  logic           last;
  logic [N:0]     a_ext;
  logic [N:0]     sum;
  logic [N:0]     part_nxt;
  logic [N-1:0]   low_nxt;
  logic [2*N-1:0] prod_nxt;

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (cnt_q == CNT_W'(N - 1));
  assign a_ext  = sgn_q ? {a_q[N-1], a_q} : {1'b0, a_q};

  // Signed mode weights the multiplier MSB negatively, hence the final subtract.
  always_comb begin
    sum = part_q;
    if (b_q[0]) begin
      if (sgn_q && last) sum = part_q - a_ext;
      else               sum = part_q + a_ext;
    end
  end

  // Unsigned sums may carry into bit N, so only signed mode replicates it on shift.
  assign part_nxt = {sgn_q & sum[N], sum[N:1]};
  assign low_nxt  = {sum[0], low_q[N-1:1]};
  assign prod_nxt = {part_nxt[N-1:0], low_nxt};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state == RUN) || (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      part_q   <= '0;
      low_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef ACCUMULATE_MODE_EN
      clr_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_q    <= bus.in_a;
      b_q    <= bus.in_b;
      sgn_q  <= bus.in_signed;
      part_q <= '0;
      low_q  <= '0;
      cnt_q  <= '0;
`ifdef ACCUMULATE_MODE_EN
      clr_q  <= bus.in_clear;
`endif
    end else if (state == RUN) begin
      part_q <= part_nxt;
      low_q  <= low_nxt;
      b_q    <= b_q >> 1;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last) begin
`ifdef ACCUMULATE_MODE_EN
        result_q <= clr_q ? prod_nxt : result_q + prod_nxt;
`else
        result_q <= prod_nxt;
`endif
      end
    end
  end

  assign bus.out_product = result_q;

endmodule

// File: tb/tb_bit_serial_mult_unit.sv
// Directed and random checks of bit_serial_mult_unit at N=8 and N=13.
// Build with ACCUMULATE_MODE_EN to add the accumulator sequence.
module tb_bit_serial_mult_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_mult_unit_if #(.N(8))  b8();
  bit_serial_mult_unit_if #(.N(13)) b13();

  bit_serial_mult_unit #(.N(8))  u8  (.clk(clk), .reset_n(reset_n), .bus(b8.slave));
  bit_serial_mult_unit #(.N(13)) u13 (.clk(clk), .reset_n(reset_n), .bus(b13.slave));

`ifdef ACCUMULATE_MODE_EN
  logic clear_sel = 1'b1;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8] = '{
    '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
    '{8'h80, 8'h80, 1'b1, 16'h4000},
    '{8'hFF, 8'h7F, 1'b1, 16'hFF81},
    '{8'h03, 8'hFB, 1'b1, 16'hFFF1},
    '{8'h80, 8'h02, 1'b0, 16'h0100},
    '{8'h00, 8'h00, 1'b0, 16'h0000},
    '{8'hFF, 8'hFF, 1'b1, 16'h0001},
    '{8'h0F, 8'h10, 1'b0, 16'h00F0}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ready(input int sel);
    return (sel != 0) ? b13.in_ready : b8.in_ready;
  endfunction

  function automatic logic get_valid(input int sel);
    return (sel != 0) ? b13.out_valid : b8.out_valid;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? b13.busy : b8.busy;
  endfunction

  function automatic logic [63:0] get_prod(input int sel);
    return (sel != 0) ? 64'(b13.out_product) : 64'(b8.out_product);
  endfunction

  function automatic logic [63:0] ref_mul(input int n, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint ai, bi, pr;
    ai = longint'(a);
    bi = longint'(b);
    if (s && a[n-1]) ai = ai - (longint'(1) << n);
    if (s && b[n-1]) bi = bi - (longint'(1) << n);
    pr = ai * bi;
    return 64'(pr) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  task automatic drive(input int sel, input logic v, input logic [12:0] a, input logic [12:0] b,
                       input logic s);
    if (sel == 0) begin
      b8.in_valid  = v;
      b8.in_a      = a[7:0];
      b8.in_b      = b[7:0];
      b8.in_signed = s;
`ifdef ACCUMULATE_MODE_EN
      b8.in_clear  = clear_sel;
`endif
    end else begin
      b13.in_valid  = v;
      b13.in_a      = a;
      b13.in_b      = b;
      b13.in_signed = s;
`ifdef ACCUMULATE_MODE_EN
      b13.in_clear  = clear_sel;
`endif
    end
  endtask

  task automatic set_out_ready(input int sel, input logic v);
    if (sel == 0) b8.out_ready = v;
    else          b13.out_ready = v;
  endtask

  // Presents operands once in_ready is seen, then scrambles them after the accept edge.
  task automatic start(input int sel, input logic [12:0] a, input logic [12:0] b, input logic s,
                       output int acc_cyc);
    int t;
    t = 0;
    while (!get_ready(sel) && t < 50) begin
      tick();
      t++;
    end
    drive(sel, 1'b1, a, b, s);
    tick();
    acc_cyc = cyc;
    drive(sel, 1'b0, ~a, ~b, ~s);
  endtask

  // Returns clocks from accept to out_valid, then completes the handoff.
  task automatic finish(input int sel, output logic [63:0] p, output int lat);
    lat = 0;
    while (!get_valid(sel) && lat < 100) begin
      tick();
      lat++;
    end
    p = get_prod(sel);
    set_out_ready(sel, 1'b1);
    tick();
    set_out_ready(sel, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    int lat, acc, prev;
    logic [12:0] ra, rb;
    logic rs;
    int n;

    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    set_out_ready(0, 1'b0);
    set_out_ready(1, 1'b0);
    #2 reset_n = 1'b0;
    #20;
    check("rst_in_ready", get_ready(0), 1);
    check("rst_out_valid", get_valid(0), 0);
    check("rst_busy", get_busy(0), 0);
    check("rst_product", get_prod(0), 0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      start(0, 13'(vecs[i].a), 13'(vecs[i].b), vecs[i].s, acc);
      check("run_in_ready", get_ready(0), 0);
      check("run_busy", get_busy(0), 1);
      finish(0, p, lat);
      check($sformatf("dir_prod[%0d]", i), p, 64'(vecs[i].exp));
      check($sformatf("dir_latency[%0d]", i), 64'(lat), 8);
      check("post_handoff_ready", get_ready(0), 1);
    end

    // Back-pressure: product must hold while in_valid pulses are ignored.
    start(0, 13'h12, 13'h34, 1'b0, acc);
    lat = 0;
    while (!get_valid(0) && lat < 100) begin
      tick();
      lat++;
    end
    check("bp_prod", get_prod(0), 64'h03A8);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 13'(k + 5), 13'(k + 9), 1'b1);
      tick();
      check("bp_valid_hold", get_valid(0), 1);
      check("bp_prod_hold", get_prod(0), 64'h03A8);
      check("bp_ready_low", get_ready(0), 0);
    end
    drive(0, 1'b0, '0, '0, 1'b0);
    set_out_ready(0, 1'b1);
    tick();
    set_out_ready(0, 1'b0);
    check("bp_handoff_valid", get_valid(0), 0);
    check("bp_handoff_ready", get_ready(0), 1);
    tick();
    check("bp_no_capture", get_busy(0), 0);
    check("bp_prod_retained", get_prod(0), 64'h03A8);

    // Reset while bit 3 is about to be processed.
    start(0, 13'hAB, 13'hCD, 1'b0, acc);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", get_ready(0), 1);
    check("mid_rst_valid", get_valid(0), 0);
    check("mid_rst_busy", get_busy(0), 0);
    check("mid_rst_prod", get_prod(0), 0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    start(0, 13'd7, 13'd9, 1'b0, acc);
    finish(0, p, lat);
    check("post_rst_prod", p, 64'h003F);
    check("post_rst_latency", 64'(lat), 8);

`ifdef ACCUMULATE_MODE_EN
    clear_sel = 1'b1;
    start(0, 13'd10, 13'd10, 1'b0, acc);
    finish(0, p, lat);
    check("acc_clear", p, 64'h0064);
    clear_sel = 1'b0;
    start(0, 13'd20, 13'd20, 1'b0, acc);
    finish(0, p, lat);
    check("acc_add", p, 64'h01F4);
    clear_sel = 1'b1;
    start(0, 13'hFF, 13'hFF, 1'b0, acc);
    finish(0, p, lat);
    check("acc_load_fe01", p, 64'hFE01);
    clear_sel = 1'b0;
    start(0, 13'd2, 13'hFF, 1'b0, acc);
    finish(0, p, lat);
    check("acc_ffff", p, 64'hFFFF);
    start(0, 13'd1, 13'd1, 1'b0, acc);
    finish(0, p, lat);
    check("acc_wrap", p, 64'h0000);
    clear_sel = 1'b1;
`endif

    for (int sel = 0; sel < 2; sel++) begin
      n = (sel != 0) ? 13 : 8;
      prev = 0;
      for (int i = 0; i < 1000; i++) begin
        ra = 13'($urandom) & 13'((1 << n) - 1);
        rb = 13'($urandom) & 13'((1 << n) - 1);
        rs = 1'($urandom_range(0, 1));
        start(sel, ra, rb, rs, acc);
        finish(sel, p, lat);
        check($sformatf("rand_prod_n%0d a=%0h b=%0h s=%0d", n, ra, rb, rs), p,
              ref_mul(n, 32'(ra), 32'(rb), rs));
        check($sformatf("rand_latency_n%0d", n), 64'(lat), 64'(n));
        if (i > 0) check($sformatf("rand_ii_n%0d", n), 64'(acc - prev), 64'(n + 2));
        prev = acc;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_mult_unit.md
Name: bit_serial_mult_unit

Overview:
- Word-level wrapper around a parametrised serial-parallel multiplier core.
- Accepts two N-bit operands over a valid/ready handshake.
- Multiplicand a is held in parallel; multiplier b is consumed LSB-first, one bit per clock.
- Produces the full 2N-bit product over a valid/ready handshake.
- Supports unsigned and two's-complement signed mode, selected per transaction.
- Next-generation multiplier for the datapath: replaces free-running bit-serial framing (first_bit/last_bit) with handshaked, resettable word transactions.

Parameters:
- N, default 8: operand width in bits; legal range N >= 2.
- CNT_W, default $clog2(N): bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- in_a  input  N  multiplicand.
- in_b  input  N  multiplier; shifted out LSB-first internally.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer accepts the product.
- out_product  output  2N  product; two's complement when in_signed was set.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, out_product=0, counter=0, accumulator=0.
- Reset asserted mid-RUN or in DONE: transaction discarded, nothing emitted.
- States:
  - IDLE -> RUN on in_valid & in_ready. Latch a, b, signed flag; clear the (N+1)-bit partial sum; counter=0.
  - RUN, one cycle per multiplier bit i=0..N-1:
    - If b_i=1, add the (N+1)-bit extended a to the partial sum. Sign-extend in signed mode, zero-extend in unsigned mode.
    - Exception: signed mode with i=N-1 subtracts extended a instead of adding.
    - Arithmetic shift right the {partial, low} pair by one. The LSB shifted out fills product bit i of the low register.
    - Counter increments. On i=N-1, go to DONE.
  - DONE: out_valid=1 and out_product={partial[N-1:0], low}. Hold stable until out_ready. On out_valid & out_ready, go to IDLE.
- Latency:
  - Accept edge -> out_valid high after exactly N clocks.
  - Minimum initiation interval is N+2 clocks: no accept in the same cycle as product handoff; in_ready rises in the cycle after handoff.
- in_valid while not in IDLE is ignored; no operands are captured.
- in_a, in_b and in_signed may change after acceptance without effect.
- Width rules:
  - The N+1 internal bits prevent overflow for all inputs.
  - Unsigned max (2^N-1)^2 and signed min*min = 2^(2N-2) are both exactly representable.
- out_product is registered. It is undefined for consumers outside DONE, but the RTL holds the last value.

Optional Feature:
- Macro ACCUMULATE_MODE_EN.
- When defined:
  - Adds port in_clear (input, 1), sampled at accept.
  - Adds a 2N-bit accumulator register.
  - On entry to DONE: accumulator = product if in_clear=1, else accumulator + product (modulo 2^(2N); sign follows in_signed).
  - out_product presents the accumulator, not the raw product.
  - Accumulator is reset to 0 and retained across transactions.
- When undefined: no in_clear port, no accumulator; out_product = raw product.

Test Plan:
- N=8, unsigned 255*255 -> out_product=0xFE01; out_valid exactly 8 clocks after accept; in_ready=0 during RUN.
- N=8, signed -128*-128 -> 0x4000; signed -1*127 -> 0xFF81; signed 3*-5 -> 0xFFF1; unsigned 0x80*0x02 -> 0x0100.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_product stable; in_valid pulses ignored; handoff on out_ready=1; in_ready=1 the next cycle.
- Reset mid-RUN at bit 3, then release -> in_ready=1, out_valid=0, out_product=0. The next transaction 7*9 yields 0x003F with no residue.
- Back-to-back random signed/unsigned pairs (1000, N=8 and N=13) -> every product matches a reference model; initiation interval = N+2.
- ACCUMULATE_MODE_EN, N=8 unsigned: 10*10 with clear=1, then 20*20 with clear=0 -> 0x0064 then 0x01F4. Wrap case: accumulator 0xFFFF + 1*1 -> 0x0000.
